// File: rtl/stream_perf_monitor.sv
// Per-channel AXI-Stream beat/stall/packet counters with snapshot readout.
// Also drives a free-running heartbeat on the LEDs.
module stream_perf_monitor #(
    parameter int NUM_CH    = 3,
    parameter int CNT_WIDTH = 32,
    parameter int SAT       = 1,
    parameter int HB_BIT    = 23,
    parameter int LED_WIDTH = 4
) (
    input  logic                 c0_ddr4_clk,
    input  logic                 axi_resetn,
    input  logic [NUM_CH-1:0]    mon_tvalid,
    input  logic [NUM_CH-1:0]    mon_tready,
    input  logic [NUM_CH-1:0]    mon_tlast,
    input  logic                 err_in,
    input  logic                 clear,
    input  logic                 snap,
    input  logic [7:0]           rd_sel,
    output logic [31:0]          rd_data,
    output logic [LED_WIDTH-1:0] user_led
);

    logic [1:0]           r_rst_sync;
    logic                 w_rst_n;

    logic [CNT_WIDTH-1:0] r_beat   [NUM_CH];
    logic [CNT_WIDTH-1:0] r_stall  [NUM_CH];
    logic [CNT_WIDTH-1:0] r_pkt    [NUM_CH];
    logic [CNT_WIDTH-1:0] r_sbeat  [NUM_CH];
    logic [CNT_WIDTH-1:0] r_sstall [NUM_CH];
    logic [CNT_WIDTH-1:0] r_spkt   [NUM_CH];
    logic [NUM_CH-1:0]    r_ovf;
    logic                 r_err;
    logic [31:0]          r_hb;
    logic [31:0]          r_rd;

    logic [CNT_WIDTH:0]   w_beat_nx  [NUM_CH];
    logic [CNT_WIDTH:0]   w_stall_nx [NUM_CH];
    logic [CNT_WIDTH:0]   w_pkt_nx   [NUM_CH];
    logic [31:0]          w_rd;
    logic                 w_unused;

    // Returns {overflow, next value}; overflow fires on any event at all-ones.
    function automatic logic [CNT_WIDTH:0] f_bump(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic                 ev
    );
        if (!ev)
            return {1'b0, cnt};
        if (&cnt)
            return (SAT != 0) ? {1'b1, cnt} : {1'b1, {CNT_WIDTH{1'b0}}};
        return {1'b0, cnt + 1'b1};
    endfunction

    // Assert asynchronously, release after two clean edges.
    always_ff @(posedge c0_ddr4_clk or negedge axi_resetn) begin
        if (!axi_resetn)
            r_rst_sync <= 2'b00;
        else
            r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_beat_nx[c]  = f_bump(r_beat[c],
                                   mon_tvalid[c] & mon_tready[c]);
            w_stall_nx[c] = f_bump(r_stall[c],
                                   mon_tvalid[c] & ~mon_tready[c]);
            w_pkt_nx[c]   = f_bump(r_pkt[c],
                                   mon_tvalid[c] & mon_tready[c] & mon_tlast[c]);
        end
    end

    always_ff @(posedge c0_ddr4_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_beat[c]   <= '0;
                r_stall[c]  <= '0;
                r_pkt[c]    <= '0;
                r_sbeat[c]  <= '0;
                r_sstall[c] <= '0;
                r_spkt[c]   <= '0;
            end
            r_ovf <= '0;
            r_err <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (snap) begin
                    r_sbeat[c]  <= r_beat[c];
                    r_sstall[c] <= r_stall[c];
                    r_spkt[c]   <= r_pkt[c];
                end
                if (clear) begin
                    r_beat[c]  <= '0;
                    r_stall[c] <= '0;
                    r_pkt[c]   <= '0;
                    r_ovf[c]   <= 1'b0;
                end else begin
                    r_beat[c]  <= w_beat_nx[c][CNT_WIDTH-1:0];
                    r_stall[c] <= w_stall_nx[c][CNT_WIDTH-1:0];
                    r_pkt[c]   <= w_pkt_nx[c][CNT_WIDTH-1:0];
                    r_ovf[c]   <= r_ovf[c] | w_beat_nx[c][CNT_WIDTH] |
                                  w_stall_nx[c][CNT_WIDTH] |
                                  w_pkt_nx[c][CNT_WIDTH];
                end
            end
            if (err_in)
                r_err <= 1'b1;
            else if (clear)
                r_err <= 1'b0;
        end
    end

    always_comb begin
        w_rd = 32'h0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_sel == 8'(3 * c))
                w_rd = 32'(r_sbeat[c]);
            if (rd_sel == 8'(3 * c + 1))
                w_rd = 32'(r_sstall[c]);
            if (rd_sel == 8'(3 * c + 2))
                w_rd = 32'(r_spkt[c]);
        end
        if (rd_sel == 8'(3 * NUM_CH))
            w_rd = 32'({r_ovf, r_err});
        if (rd_sel == 8'(3 * NUM_CH + 1))
            w_rd = 32'(r_beat[0]);
    end

    always_ff @(posedge c0_ddr4_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rd <= 32'h0;
            r_hb <= 32'h0;
        end else begin
            r_rd <= w_rd;
            r_hb <= r_hb + 32'd1;
        end
    end

    assign rd_data  = r_rd;
    assign user_led = r_hb[HB_BIT -: LED_WIDTH];
    assign w_unused = ^r_hb;

endmodule

// File: tb/tb_stream_perf_monitor.sv
// Bench for stream_perf_monitor: saturating and wrapping 8-bit instances
// driven together and compared against an event-count reference model.
module tb_stream_perf_monitor;

    localparam int NCH = 3;
    localparam int HB  = 5;
    localparam int LW  = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [2:0]    tv = '0, tr = '0, tl = '0;
    logic          err_in = 1'b0, clr = 1'b0, snp = 1'b0;
    logic [7:0]    sel = '0;
    logic [31:0]   rd0, rd1;
    logic [LW-1:0] led0, led1;

    int n_chk = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    stream_perf_monitor #(
        .NUM_CH(NCH), .CNT_WIDTH(8), .SAT(1), .HB_BIT(HB), .LED_WIDTH(LW)
    ) u_sat (
        .c0_ddr4_clk(clk), .axi_resetn(rstn),
        .mon_tvalid(tv), .mon_tready(tr), .mon_tlast(tl),
        .err_in(err_in), .clear(clr), .snap(snp),
        .rd_sel(sel), .rd_data(rd0), .user_led(led0)
    );

    stream_perf_monitor #(
        .NUM_CH(NCH), .CNT_WIDTH(8), .SAT(0), .HB_BIT(HB), .LED_WIDTH(LW)
    ) u_wrap (
        .c0_ddr4_clk(clk), .axi_resetn(rstn),
        .mon_tvalid(tv), .mon_tready(tr), .mon_tlast(tl),
        .err_in(err_in), .clear(clr), .snap(snp),
        .rd_sel(sel), .rd_data(rd1), .user_led(led1)
    );

    // Model: unbounded event counts since the last clear; the visible
    // counter value and overflow flag are derived from them arithmetically.
    int          nb [NCH];
    int          ns [NCH];
    int          np [NCH];
    int          snapv [2][3*NCH];
    bit          m_err = 1'b0;
    int          rel = 0;
    logic [31:0] exp_rd [2];

    function automatic int val(int n, int sat);
        if (sat != 0)
            return (n > 255) ? 255 : n;
        return n % 256;
    endfunction

    function automatic logic [31:0] rdv(int i, int s);
        logic [31:0] st;
        int sat;
        sat = (i == 0) ? 1 : 0;
        if (s < 3 * NCH)
            return 32'(snapv[i][s]);
        if (s == 3 * NCH) begin
            st = {31'b0, m_err};
            for (int c = 0; c < NCH; c++)
                if (nb[c] > 255 || ns[c] > 255 || np[c] > 255)
                    st[c+1] = 1'b1;
            return st;
        end
        if (s == 3 * NCH + 1)
            return 32'(val(nb[0], sat));
        return 32'h0;
    endfunction

    function automatic logic [31:0] exp_led();
        int hb;
        hb = (rel >= 2) ? rel - 2 : 0;
        return 32'((hb >> (HB - LW + 1)) & ((1 << LW) - 1));
    endfunction

    initial begin
        for (int c = 0; c < NCH; c++) begin
            nb[c] = 0; ns[c] = 0; np[c] = 0;
        end
        for (int i = 0; i < 2; i++) begin
            exp_rd[i] = 32'h0;
            for (int k = 0; k < 3 * NCH; k++)
                snapv[i][k] = 0;
        end
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < NCH; c++) begin
                nb[c] = 0; ns[c] = 0; np[c] = 0;
            end
            for (int i = 0; i < 2; i++) begin
                exp_rd[i] = 32'h0;
                for (int k = 0; k < 3 * NCH; k++)
                    snapv[i][k] = 0;
            end
            m_err = 1'b0;
            rel = 0;
        end else begin
            if (rel >= 2) begin
                for (int i = 0; i < 2; i++)
                    exp_rd[i] = rdv(i, int'(sel));
                if (snp)
                    for (int i = 0; i < 2; i++)
                        for (int c = 0; c < NCH; c++) begin
                            snapv[i][3*c]   = val(nb[c], (i == 0) ? 1 : 0);
                            snapv[i][3*c+1] = val(ns[c], (i == 0) ? 1 : 0);
                            snapv[i][3*c+2] = val(np[c], (i == 0) ? 1 : 0);
                        end
                if (err_in)
                    m_err = 1'b1;
                else if (clr)
                    m_err = 1'b0;
                for (int c = 0; c < NCH; c++) begin
                    if (clr) begin
                        nb[c] = 0; ns[c] = 0; np[c] = 0;
                    end else begin
                        nb[c] += int'(tv[c] & tr[c]);
                        ns[c] += int'(tv[c] & ~tr[c]);
                        np[c] += int'(tv[c] & tr[c] & tl[c]);
                    end
                end
            end
            rel++;
        end
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("rd_sat", rd0, exp_rd[0]);
            chk("rd_wrap", rd1, exp_rd[1]);
            chk("led_sat", 32'(led0), exp_led());
            chk("led_wrap", 32'(led1), exp_led());
        end
    end

    task automatic cyc(logic [2:0] v, logic [2:0] r, logic [2:0] l,
                       logic e, logic c, logic s);
        tv = v; tr = r; tl = l;
        err_in = e; clr = c; snp = s;
        @(negedge clk);
    endtask

    task automatic rd_chk(string tag, int s, logic [31:0] e0, logic [31:0] e1);
        tv = '0; tr = '0; tl = '0;
        err_in = 1'b0; clr = 1'b0; snp = 1'b0;
        sel = 8'(s);
        @(negedge clk);
        chk({tag, "_sat"}, rd0, e0);
        chk({tag, "_wrap"}, rd1, e1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rd", rd0, 32'h0);
        chk("rst_led", 32'(led0), 32'h0);
        rstn = 1'b1;
        mon_en = 1'b1;
        repeat (4) @(negedge clk);
        rd_chk("init_stat", 3 * NCH, 0, 0);

        repeat (9) cyc(3'b001, 3'b001, 3'b000, 0, 0, 0);
        cyc(3'b001, 3'b001, 3'b001, 0, 0, 0);
        cyc(3'b000, 3'b000, 3'b000, 0, 0, 1);
        rd_chk("c0_beat", 0, 10, 10);
        rd_chk("c0_stall", 1, 0, 0);
        rd_chk("c0_pkt", 2, 1, 1);

        repeat (5) cyc(3'b010, 3'b000, 3'b000, 0, 0, 0);
        repeat (2) cyc(3'b010, 3'b010, 3'b000, 0, 0, 0);
        cyc(3'b000, 3'b000, 3'b000, 0, 0, 1);
        rd_chk("c1_stall", 4, 5, 5);
        rd_chk("c1_beat", 3, 2, 2);

        cyc(3'b000, 3'b000, 3'b000, 0, 1, 0);
        repeat (300) cyc(3'b100, 3'b100, 3'b000, 0, 0, 0);
        cyc(3'b000, 3'b000, 3'b000, 0, 0, 1);
        rd_chk("c2_beat", 6, 255, 44);
        rd_chk("ovf_stat", 3 * NCH, 8, 8);

        cyc(3'b000, 3'b000, 3'b000, 0, 1, 0);
        repeat (7) cyc(3'b001, 3'b001, 3'b000, 0, 0, 0);
        cyc(3'b000, 3'b000, 3'b000, 0, 1, 1);
        rd_chk("sc_pre", 0, 7, 7);
        rd_chk("live0", 3 * NCH + 1, 0, 0);
        cyc(3'b000, 3'b000, 3'b000, 0, 0, 1);
        rd_chk("sc_post", 0, 0, 0);

        cyc(3'b000, 3'b000, 3'b000, 1, 1, 0);
        rd_chk("err_clr", 3 * NCH, 1, 1);
        cyc(3'b000, 3'b000, 3'b000, 0, 1, 0);
        rd_chk("err_off", 3 * NCH, 0, 0);

        repeat (600) begin
            sel = 8'($urandom_range(0, 12));
            cyc(3'($urandom), 3'($urandom), 3'($urandom),
                $urandom_range(0, 31) == 0,
                $urandom_range(0, 63) == 0,
                $urandom_range(0, 7) == 0);
        end

        sel = 8'(3 * NCH + 1);
        repeat (5) cyc(3'b111, 3'b111, 3'b000, 0, 0, 0);
        #2 rstn = 1'b0;
        #1;
        chk("drop_rd_sat", rd0, 32'h0);
        chk("drop_rd_wrap", rd1, 32'h0);
        chk("drop_led_sat", 32'(led0), 32'h0);
        chk("drop_led_wrap", 32'(led1), 32'h0);
        repeat (2) @(negedge clk);
        tv = '0; tr = '0;
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        rd_chk("post_rst_stat", 3 * NCH, 0, 0);
        rd_chk("post_rst_beat", 0, 0, 0);
        rd_chk("post_rst_live", 3 * NCH + 1, 0, 0);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/stream_perf_monitor.md
STREAM_PERF_MONITOR -- requirements
Module: stream_perf_monitor

Interface
REQ-001 Parameter NUM_CH, default 3, number of monitored AXI-Stream channels; legal range 1..16.
REQ-002 Parameter CNT_WIDTH, default 32, width of each event counter; legal range 8..32.
REQ-003 Parameter SAT, default 1; 1 = counters saturate, 0 = counters wrap.
REQ-004 Parameter HB_BIT, default 23, MSB of the heartbeat slice driven to the LEDs; must be at least LED_WIDTH-1.
REQ-005 Parameter LED_WIDTH, default 4, heartbeat LED width.
REQ-006 c0_ddr4_clk  input  1  sole clock; all logic is clocked on its rising edge.
REQ-007 axi_resetn  input  1  asynchronous, active-low reset.
REQ-008 mon_tvalid  input  NUM_CH  per-channel tvalid, observed only, never driven.
REQ-009 mon_tready  input  NUM_CH  per-channel tready, observed only.
REQ-010 mon_tlast  input  NUM_CH  per-channel tlast, observed only.
REQ-011 err_in  input  1  error strobe from the core.
REQ-012 clear  input  1  single-cycle pulse that zeroes live counters, overflow flags and the sticky error.
REQ-013 snap  input  1  single-cycle pulse that copies all live counters into the snapshot bank.
REQ-014 rd_sel  input  8  readout selector.
REQ-015 rd_data  output  32  registered readout word.
REQ-016 user_led  output  LED_WIDTH  heartbeat slice.

Function
REQ-017 Each channel c SHALL keep three counters:
- beat[c]: counts +1 on tvalid & tready.
- stall[c]: counts +1 on tvalid & !tready.
- pkt[c]: counts +1 on tvalid & tready & tlast.
REQ-018 All counters SHALL update in the cycle after the qualifying input; there are no multi-cycle paths.
REQ-019 With SAT=1, a counter at all-ones SHALL hold its value and set ovf[c] on any further event.
REQ-020 With SAT=0, a counter SHALL wrap from all-ones to 0 and set ovf[c] on the wrap.
REQ-021 ovf[c] SHALL be a single sticky bit per channel, shared by that channel's three counters.
REQ-022 clear SHALL zero all live counters and all ovf bits; events in the clear cycle are not counted.
REQ-023 err_sticky SHALL set on err_in and clear on clear; if err_in and clear are asserted together, err_sticky ends at 1.
REQ-024 snap SHALL load every snapshot register from its live counter's value before that cycle's update.
REQ-025 If snap and clear are asserted together, the snapshot SHALL hold the pre-clear values and the live counters SHALL go to 0.
REQ-026 Snapshot registers SHALL be changed only by snap and reset; clear does not affect them.
REQ-027 The readout map SHALL be:
- rd_sel = 3c+0: snapshot beat[c].
- rd_sel = 3c+1: snapshot stall[c].
- rd_sel = 3c+2: snapshot pkt[c].
- rd_sel = 3*NUM_CH: status word {zeros, ovf[NUM_CH-1:0], err_sticky}, with err_sticky at bit 0.
- rd_sel = 3*NUM_CH+1: live beat[0], for a free-running check.
- all other values: 32'h0.
REQ-028 Counter values in rd_data SHALL be zero-extended to 32 bits.
REQ-029 rd_data SHALL be registered with 1-cycle latency from rd_sel.
REQ-030 Readout SHALL reflect register state at the sampling edge; a snap in cycle N is visible when rd_sel is presented in N+1, with data in N+2.
REQ-031 A free-running 32-bit heartbeat counter SHALL increment every cycle and wrap at 2^32.
REQ-032 The heartbeat counter SHALL be unaffected by clear and snap.
REQ-033 user_led SHALL equal hb[HB_BIT:HB_BIT-LED_WIDTH+1].
REQ-034 Channels SHALL be fully independent; simultaneous events on all channels are all counted.

Reset
REQ-035 Assertion of axi_resetn=0 SHALL immediately zero all counters, snapshots, ovf, err_sticky, the heartbeat counter, rd_data and user_led.
REQ-036 Deassertion SHALL be synchronised internally; the first counted event is the first qualifying cycle after two clean edges.
REQ-037 Reset mid-packet SHALL discard all in-flight counts with no partial state.

Verification
REQ-038 NUM_CH=3: ch0 valid=ready=1 for 10 cycles, tlast on cycle 10; snap; rd_sel=0,1,2 -> 10, 0, 1.
REQ-039 ch1 valid=1, ready=0 for 5 cycles then ready=1 for 2; snap; rd_sel=4 -> 5, rd_sel=3 -> 2.
REQ-040 CNT_WIDTH=8, SAT=1: 300 beats on ch2; snap -> rd_sel=6 = 255, status bit3 = 1. Repeat with SAT=0 -> 44, bit3 = 1.
REQ-041 snap and clear in the same cycle after 7 beats on ch0 -> rd_sel=0 = 7; next snap -> 0.
REQ-042 err_in and clear in the same cycle -> status bit0 = 1. clear alone the next cycle -> bit0 = 0.
REQ-043 Drop axi_resetn mid-stream -> rd_data = 0 and user_led = 0 within the same cycle; rd_sel=9 reads 0 before any new beat.
